// File: rtl/secuenciador_bebida.sv
// secuenciador_bebida
// Drink dispenser sequencer. A start request latches the drink and sugar
// selection, then opens one valve at a time in the fixed order
// agua -> cafe -> leche -> choco -> azucar. Each valve stays open for its
// recipe duration in whole seconds. Steps with zero duration are skipped.
// A one-cycle LISTA state with a completion pulse closes the sequence.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   iniciar       start request (sampled only in IDLE)
//   bebida[1:0]   drink: 0 expreso, 1 cafe con leche, 2 capuccino, 3 chocolate
//   azucar_sel    add sugar (sampled together with iniciar)
//   abortar       cancel the drink in progress (ingredient states only)
//   agua..azucar  registered valve enables, at most one high
//   ocupado       high in every state except IDLE
//   bebida_lista  one-cycle completion pulse
//   abortado      one-cycle cancel pulse
//   estado[2:0]   current state code
//   seg_restantes whole seconds left in the current step, 0 otherwise
module secuenciador_bebida #(
  parameter int TICKS_PER_SEG = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iniciar,
  input  logic [1:0] bebida,
  input  logic       azucar_sel,
  input  logic       abortar,
  output logic       agua,
  output logic       cafe,
  output logic       leche,
  output logic       choco,
  output logic       azucar,
  output logic       ocupado,
  output logic       bebida_lista,
  output logic       abortado,
  output logic [2:0] estado,
  output logic [1:0] seg_restantes
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    AGUA   = 3'd1,
    CAFE   = 3'd2,
    LECHE  = 3'd3,
    CHOCO  = 3'd4,
    AZUCAR = 3'd5,
    LISTA  = 3'd6
  } state_t;

  // A prescaler of width 1 still works when TICKS_PER_SEG is 1: it stays at 0
  // and wraps every cycle.
  localparam int PW = (TICKS_PER_SEG > 1) ? $clog2(TICKS_PER_SEG) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEG - 1);

  // Recipe table: seconds each step lasts for a given selection.
  function automatic logic [1:0] dur_of(input state_t s, input logic [1:0] b,
                                        input logic a);
    logic [1:0] d;
    d = 2'd0;
    case (s)
      AGUA:   d = (b == 2'd0 || b == 2'd3) ? 2'd2 : 2'd1;
      CAFE:   case (b)
                2'd0:    d = 2'd3;
                2'd1:    d = 2'd2;
                2'd2:    d = 2'd2;
                default: d = 2'd0;
              endcase
      LECHE:  case (b)
                2'd0:    d = 2'd0;
                2'd1:    d = 2'd2;
                2'd2:    d = 2'd3;
                default: d = 2'd2;
              endcase
      CHOCO:  case (b)
                2'd2:    d = 2'd1;
                2'd3:    d = 2'd3;
                default: d = 2'd0;
              endcase
      AZUCAR: d = a ? 2'd1 : 2'd0;
      default: d = 2'd0;
    endcase
    return d;
  endfunction

  // First step after s with a nonzero duration, or LISTA if none remains.
  // Scanning downwards lets the lowest qualifying step win.
  function automatic state_t next_step(input state_t s, input logic [1:0] b,
                                       input logic a);
    state_t n;
    n = LISTA;
    for (int k = 5; k >= 1; k--) begin
      if (k > int'(s) && dur_of(state_t'(3'(k)), b, a) != 2'd0)
        n = state_t'(3'(k));
    end
    return n;
  endfunction

  state_t        state_reg;
  state_t        state_next;
  logic [1:0]    bebida_reg;
  logic          azucar_reg;
  logic [PW-1:0] presc_reg;
  logic [1:0]    seg_cnt_reg;

  logic          in_step;
  logic          wrap;
  logic          step_done;
  logic          abort_now;
  logic          counting;
  logic [1:0]    dur_cur;
  logic [1:0]    sel_b;
  logic          sel_a;
  logic [1:0]    seg_next;

  always_comb begin
    in_step    = (state_reg inside {AGUA, CAFE, LECHE, CHOCO, AZUCAR});
    dur_cur    = dur_of(state_reg, bebida_reg, azucar_reg);
    wrap       = (presc_reg == PRESC_MAX);
    step_done  = wrap && (seg_cnt_reg == dur_cur - 2'd1);
    // In IDLE the selection is latched on this same edge, so the first step
    // has to be chosen from the live inputs.
    sel_b      = (state_reg == IDLE) ? bebida : bebida_reg;
    sel_a      = (state_reg == IDLE) ? azucar_sel : azucar_reg;
    state_next = state_reg;
    abort_now  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (iniciar)
          state_next = next_step(IDLE, bebida, azucar_sel);
      end
      AGUA, CAFE, LECHE, CHOCO, AZUCAR: begin
        if (abortar) begin
          state_next = IDLE;
          abort_now  = 1'b1;
        end else if (step_done) begin
          state_next = next_step(state_reg, bebida_reg, azucar_reg);
        end
      end
      default: state_next = IDLE;  // LISTA lasts exactly one cycle
    endcase

    // Next steps are always strictly later in the order, so staying in the
    // same ingredient state means the current step keeps running.
    counting = in_step && (state_next == state_reg);

    if (!(state_next inside {AGUA, CAFE, LECHE, CHOCO, AZUCAR}))
      seg_next = 2'd0;
    else if (!counting)
      seg_next = dur_of(state_next, sel_b, sel_a);
    else if (wrap)
      seg_next = seg_restantes - 2'd1;
    else
      seg_next = seg_restantes;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      bebida_reg    <= 2'd0;
      azucar_reg    <= 1'b0;
      presc_reg     <= '0;
      seg_cnt_reg   <= 2'd0;
      agua          <= 1'b0;
      cafe          <= 1'b0;
      leche         <= 1'b0;
      choco         <= 1'b0;
      azucar        <= 1'b0;
      ocupado       <= 1'b0;
      bebida_lista  <= 1'b0;
      abortado      <= 1'b0;
      seg_restantes <= 2'd0;
    end else begin
      state_reg <= state_next;

      if (state_reg == IDLE && iniciar) begin
        bebida_reg <= bebida;
        azucar_reg <= azucar_sel;
      end

      // Timebase restarts from zero on entry to every step.
      if (counting) begin
        presc_reg   <= wrap ? '0 : presc_reg + 1'b1;
        seg_cnt_reg <= wrap ? seg_cnt_reg + 2'd1 : seg_cnt_reg;
      end else begin
        presc_reg   <= '0;
        seg_cnt_reg <= 2'd0;
      end

      agua          <= (state_next == AGUA);
      cafe          <= (state_next == CAFE);
      leche         <= (state_next == LECHE);
      choco         <= (state_next == CHOCO);
      azucar        <= (state_next == AZUCAR);
      ocupado       <= (state_next != IDLE);
      bebida_lista  <= (state_next == LISTA);
      abortado      <= abort_now;
      seg_restantes <= seg_next;
    end
  end

  assign estado = state_reg;

endmodule
